// File: rtl/warp_fetch_ctrl.sv
// Per-warp PC/active bookkeeping with a round-robin fetch arbiter and a registered
// fetch request. Optional misaligned-jump trap: define WFC_MISALIGN_CHK_EN.
module warp_fetch_ctrl #(
    parameter int NUM_WARP   = 8,
    parameter int DEPTH_WARP = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  warp_start_valid_i,
    input  logic [DEPTH_WARP-1:0] warp_start_wid_i,
    input  logic [31:0]           warp_start_pc_i,
    input  logic                  warp_end_valid_i,
    input  logic [DEPTH_WARP-1:0] warp_end_wid_i,
    input  logic [NUM_WARP-1:0]   warp_stall_i,
    input  logic                  jump_valid_i,
    output logic                  jump_ready_o,
    input  logic [DEPTH_WARP-1:0] jump_wid_i,
    input  logic                  jump_i,
    input  logic [31:0]           jump_new_pc_i,
    output logic                  fetch_req_valid_o,
    input  logic                  fetch_req_ready_i,
    output logic [DEPTH_WARP-1:0] fetch_req_wid_o,
    output logic [31:0]           fetch_req_pc_o,
    output logic                  err_o
);

    logic [NUM_WARP-1:0]   active_q, active_d;
    logic [31:0]           pc_q [NUM_WARP];
    logic [31:0]           pc_d [NUM_WARP];
    logic [DEPTH_WARP-1:0] last_q, last_d;
    logic                  req_valid_q, req_valid_d;
    logic [DEPTH_WARP-1:0] req_wid_q, req_wid_d;
    logic [31:0]           req_pc_q, req_pc_d;

    logic                  fire;
    logic                  jump_apply;
    logic [NUM_WARP-1:0]   eligible;
    logic                  grant_found;
    logic [DEPTH_WARP-1:0] grant_wid;

    assign jump_ready_o      = 1'b1;
    assign fire              = req_valid_q & fetch_req_ready_i;
    assign fetch_req_valid_o = req_valid_q;
    assign fetch_req_wid_o   = req_wid_q;
    assign fetch_req_pc_o    = req_pc_q;

    // A jump is dropped when a start or end for the same warp arrives together.
    assign jump_apply = jump_valid_i && jump_i && active_q[jump_wid_i]
                        && !(warp_end_valid_i && (warp_end_wid_i == jump_wid_i))
                        && !(warp_start_valid_i && (warp_start_wid_i == jump_wid_i));

`ifdef WFC_MISALIGN_CHK_EN
    logic err_q, err_d;
    logic jump_misaligned;

    assign jump_misaligned = (jump_new_pc_i[1:0] != 2'b00);
    assign err_o           = err_q;
`else
    assign err_o = 1'b0;
`endif

    // The firing warp is excluded so it cannot be re-issued with a stale pc.
    always_comb begin
        eligible = '0;
        for (int unsigned w = 0; w < NUM_WARP; w++) begin
            eligible[DEPTH_WARP'(w)] = active_q[DEPTH_WARP'(w)]
                                      & ~warp_stall_i[DEPTH_WARP'(w)]
                                      & ~(fire && (req_wid_q == DEPTH_WARP'(w)));
        end
    end

    always_comb begin
        int unsigned idx;
        grant_found = 1'b0;
        grant_wid   = '0;
        idx         = 0;
        for (int unsigned i = 1; i <= NUM_WARP; i++) begin
            idx = (32'(last_q) + i) % NUM_WARP;
            if (!grant_found && eligible[DEPTH_WARP'(idx)]) begin
                grant_found = 1'b1;
                grant_wid   = DEPTH_WARP'(idx);
            end
        end
    end

    // Later assignments win: fetch increment < jump < end < start.
    always_comb begin
        active_d = active_q;
        pc_d     = pc_q;
`ifdef WFC_MISALIGN_CHK_EN
        err_d    = err_q;
`endif
        if (fire) begin
            pc_d[req_wid_q] = req_pc_q + 32'd4;
        end
        if (jump_apply) begin
`ifdef WFC_MISALIGN_CHK_EN
            if (jump_misaligned) begin
                err_d                = 1'b1;
                active_d[jump_wid_i] = 1'b0;
                pc_d[jump_wid_i]     = pc_q[jump_wid_i];
            end else begin
                pc_d[jump_wid_i] = jump_new_pc_i;
            end
`else
            pc_d[jump_wid_i] = jump_new_pc_i & ~32'h3;
`endif
        end
        if (warp_end_valid_i) begin
            active_d[warp_end_wid_i] = 1'b0;
            pc_d[warp_end_wid_i]     = pc_q[warp_end_wid_i];
        end
        if (warp_start_valid_i) begin
            active_d[warp_start_wid_i] = 1'b1;
            pc_d[warp_start_wid_i]     = warp_start_pc_i;
        end
    end

    always_comb begin
        req_valid_d = req_valid_q;
        req_wid_d   = req_wid_q;
        req_pc_d    = req_pc_q;
        last_d      = last_q;
        if (!req_valid_q || fire) begin
            req_valid_d = grant_found;
            if (grant_found) begin
                req_wid_d = grant_wid;
                req_pc_d  = pc_q[grant_wid];
                last_d    = grant_wid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q    <= '0;
            pc_q        <= '{default: '0};
            last_q      <= DEPTH_WARP'(NUM_WARP - 1);
            req_valid_q <= 1'b0;
            req_wid_q   <= '0;
            req_pc_q    <= '0;
        end else begin
            active_q    <= active_d;
            pc_q        <= pc_d;
            last_q      <= last_d;
            req_valid_q <= req_valid_d;
            req_wid_q   <= req_wid_d;
            req_pc_q    <= req_pc_d;
        end
    end

`ifdef WFC_MISALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_warp_fetch_ctrl.sv
// Directed bench for warp_fetch_ctrl: a warp-level behavioural model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_warp_fetch_ctrl;
    localparam int NW = 8;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          warp_start_valid_i;
    logic [DW-1:0] warp_start_wid_i;
    logic [31:0]   warp_start_pc_i;
    logic          warp_end_valid_i;
    logic [DW-1:0] warp_end_wid_i;
    logic [NW-1:0] warp_stall_i;
    logic          jump_valid_i;
    logic          jump_ready_o;
    logic [DW-1:0] jump_wid_i;
    logic          jump_i;
    logic [31:0]   jump_new_pc_i;
    logic          fetch_req_valid_o;
    logic          fetch_req_ready_i;
    logic [DW-1:0] fetch_req_wid_o;
    logic [31:0]   fetch_req_pc_o;
    logic          err_o;

    warp_fetch_ctrl #(.NUM_WARP(NW), .DEPTH_WARP(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .warp_start_valid_i(warp_start_valid_i), .warp_start_wid_i(warp_start_wid_i),
        .warp_start_pc_i(warp_start_pc_i),
        .warp_end_valid_i(warp_end_valid_i), .warp_end_wid_i(warp_end_wid_i),
        .warp_stall_i(warp_stall_i),
        .jump_valid_i(jump_valid_i), .jump_ready_o(jump_ready_o), .jump_wid_i(jump_wid_i),
        .jump_i(jump_i), .jump_new_pc_i(jump_new_pc_i),
        .fetch_req_valid_o(fetch_req_valid_o), .fetch_req_ready_i(fetch_req_ready_i),
        .fetch_req_wid_o(fetch_req_wid_o), .fetch_req_pc_o(fetch_req_pc_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Warp-level model: what each warp is doing and what request should be on the port.
    bit          m_act [NW];
    logic [31:0] m_pc  [NW];
    int          m_last;
    bit          m_valid;
    int          m_wid;
    logic [31:0] m_out_pc;
    bit          m_err;

    int          log_wid [$];
    logic [31:0] log_pc  [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_act[w] = 1'b0;
            m_pc[w]  = 32'h0;
        end
        m_last   = NW - 1;
        m_valid  = 1'b0;
        m_wid    = 0;
        m_out_pc = 32'h0;
        m_err    = 1'b0;
    endtask

    task automatic model_step();
        bit          fire;
        bit          jmp;
        int          pick;
        int          w;
        int          jw;
        int          ew;
        int          sw;
        bit          n_act [NW];
        logic [31:0] n_pc  [NW];
        fire = m_valid && (fetch_req_ready_i === 1'b1);
        jw   = int'(jump_wid_i);
        ew   = int'(warp_end_wid_i);
        sw   = int'(warp_start_wid_i);
        pick = -1;
        for (int k = 1; k <= NW; k++) begin
            w = (m_last + k) % NW;
            if (pick < 0 && m_act[w] && !warp_stall_i[w[DW-1:0]] && !(fire && w == m_wid))
                pick = w;
        end
        n_act = m_act;
        n_pc  = m_pc;
        if (fire) n_pc[m_wid] = m_out_pc + 32'd4;
        jmp = jump_valid_i && jump_i && m_act[jw]
              && !(warp_end_valid_i && ew == jw) && !(warp_start_valid_i && sw == jw);
        if (jmp) begin
`ifdef WFC_MISALIGN_CHK_EN
            if (jump_new_pc_i[1:0] != 2'b00) begin
                m_err     = 1'b1;
                n_act[jw] = 1'b0;
                n_pc[jw]  = m_pc[jw];
            end else begin
                n_pc[jw] = jump_new_pc_i;
            end
`else
            n_pc[jw] = {jump_new_pc_i[31:2], 2'b00};
`endif
        end
        if (warp_end_valid_i) begin
            n_act[ew] = 1'b0;
            n_pc[ew]  = m_pc[ew];
        end
        if (warp_start_valid_i) begin
            n_act[sw] = 1'b1;
            n_pc[sw]  = warp_start_pc_i;
        end
        if (!m_valid || fire) begin
            if (pick >= 0) begin
                m_valid  = 1'b1;
                m_wid    = pick;
                m_out_pc = m_pc[pick];
                m_last   = pick;
            end else begin
                m_valid = 1'b0;
            end
        end
        m_act = n_act;
        m_pc  = n_pc;
    endtask

    task automatic check_outputs();
        chk("valid", 32'(fetch_req_valid_o), 32'(m_valid));
        if (m_valid) begin
            chk("wid", 32'(fetch_req_wid_o), 32'(m_wid));
            chk("pc", fetch_req_pc_o, m_out_pc);
        end
        chk("err", 32'(err_o), 32'(m_err));
        chk("jump_ready", 32'(jump_ready_o), 32'd1);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
        if (fetch_req_valid_o === 1'b1) begin
            log_wid.push_back(int'(fetch_req_wid_o));
            log_pc.push_back(fetch_req_pc_o);
        end
    endtask

    task automatic clear_inputs();
        warp_start_valid_i = 1'b0;
        warp_start_wid_i   = '0;
        warp_start_pc_i    = '0;
        warp_end_valid_i   = 1'b0;
        warp_end_wid_i     = '0;
        warp_stall_i       = '0;
        jump_valid_i       = 1'b0;
        jump_wid_i         = '0;
        jump_i             = 1'b0;
        jump_new_pc_i      = '0;
        fetch_req_ready_i  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 32'(fetch_req_valid_o), 32'd0);
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        log_wid.delete();
        log_pc.delete();
    endtask

    task automatic start_warp(input int wid, input logic [31:0] pc);
        warp_start_valid_i = 1'b1;
        warp_start_wid_i   = DW'(wid);
        warp_start_pc_i    = pc;
        cycle();
        warp_start_valid_i = 1'b0;
    endtask

    task automatic set_jump(input int wid, input bit redirect, input logic [31:0] pc);
        jump_valid_i  = 1'b1;
        jump_wid_i    = DW'(wid);
        jump_i        = redirect;
        jump_new_pc_i = pc;
    endtask

    initial begin
        bit vb [6];
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(fetch_req_valid_o), 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);
        rst_n = 1'b1;

        // Single warp: a request every other cycle, pc advancing by 4.
        fetch_req_ready_i = 1'b1;
        start_warp(0, 32'h8000_0000);
        chk("t1_c0_valid", 32'(fetch_req_valid_o), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            cycle();
            vb[i] = fetch_req_valid_o;
        end
        for (int i = 1; i <= 5; i++) chk($sformatf("t1_c%0d_valid", i), 32'(vb[i]), 32'(i % 2));
        chk("t1_count", 32'(log_pc.size()), 32'd3);
        if (log_pc.size() == 3) begin
            chk("t1_pc0", log_pc[0], 32'h8000_0000);
            chk("t1_pc1", log_pc[1], 32'h8000_0004);
            chk("t1_pc2", log_pc[2], 32'h8000_0008);
        end

        // Three warps rotate 0,1,2,0; then stalls, backpressure and jumps.
        do_reset();
        fetch_req_ready_i = 1'b1;
        start_warp(0, 32'h1000);
        start_warp(1, 32'h2000);
        start_warp(2, 32'h3000);
        repeat (3) cycle();
        chk("t2_count", 32'(log_pc.size() >= 4), 32'd1);
        if (log_pc.size() >= 4) begin
            chk("t2_wid0", 32'(log_wid[0]), 32'd0);
            chk("t2_pc0", log_pc[0], 32'h1000);
            chk("t2_wid1", 32'(log_wid[1]), 32'd1);
            chk("t2_pc1", log_pc[1], 32'h2000);
            chk("t2_wid2", 32'(log_wid[2]), 32'd2);
            chk("t2_pc2", log_pc[2], 32'h3000);
            chk("t2_wid3", 32'(log_wid[3]), 32'd0);
            chk("t2_pc3", log_pc[3], 32'h1004);
        end
        for (int i = 0; i < 30; i++) begin
            warp_stall_i      = NW'(1 << (i % 3));
            fetch_req_ready_i = (i % 3) != 1;
            if (i == 10) set_jump(1, 1'b1, 32'h7000);
            else if (i == 20) set_jump(2, 1'b0, 32'hdead_beec);
            else jump_valid_i = 1'b0;
            cycle();
        end
        jump_valid_i = 1'b0;
        warp_stall_i = '0;

        // Held request stays stable under backpressure; async reset drops it.
        do_reset();
        start_warp(1, 32'h500);
        cycle();
        chk("t3_load_valid", 32'(fetch_req_valid_o), 32'd1);
        chk("t3_load_pc", fetch_req_pc_o, 32'h500);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t3_hold_valid", 32'(fetch_req_valid_o), 32'd1);
            chk("t3_hold_wid", 32'(fetch_req_wid_o), 32'd1);
            chk("t3_hold_pc", fetch_req_pc_o, 32'h500);
        end
        fetch_req_ready_i = 1'b1;
        cycle();
        chk("t3_fire_gap", 32'(fetch_req_valid_o), 32'd0);
        cycle();
        chk("t3_next_pc", fetch_req_pc_o, 32'h504);
        fetch_req_ready_i = 1'b0;
        cycle();

        // Jump in the same cycle as a fire on that warp wins over +4.
        do_reset();
        fetch_req_ready_i = 1'b1;
        start_warp(0, 32'h40);
        cycle();
        chk("t4_pc40", fetch_req_pc_o, 32'h40);
        set_jump(0, 1'b1, 32'h100);
        cycle();
        jump_valid_i = 1'b0;
        cycle();
        chk("t4_valid", 32'(fetch_req_valid_o), 32'd1);
        chk("t4_pc100", fetch_req_pc_o, 32'h100);

        // Acknowledge-only jump, then retire while the request is held.
        do_reset();
        fetch_req_ready_i = 1'b1;
        start_warp(2, 32'h200);
        cycle();
        chk("t5_pc200", fetch_req_pc_o, 32'h200);
        set_jump(2, 1'b0, 32'h999);
        cycle();
        jump_valid_i = 1'b0;
        cycle();
        chk("t5_pc204", fetch_req_pc_o, 32'h204);
        fetch_req_ready_i = 1'b0;
        warp_end_valid_i  = 1'b1;
        warp_end_wid_i    = 3'd2;
        cycle();
        warp_end_valid_i = 1'b0;
        chk("t5_held_valid", 32'(fetch_req_valid_o), 32'd1);
        chk("t5_held_pc", fetch_req_pc_o, 32'h204);
        fetch_req_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t5_retired", 32'(fetch_req_valid_o), 32'd0);
        end

        // Misaligned jump target; an inactive warp's jump has no effect.
        do_reset();
        fetch_req_ready_i = 1'b1;
        set_jump(3, 1'b1, 32'h302);
        cycle();
        jump_valid_i = 1'b0;
        chk("t6_inactive_err", 32'(err_o), 32'd0);
        start_warp(0, 32'h0);
        cycle();
        chk("t6_pc0", fetch_req_pc_o, 32'h0);
        set_jump(0, 1'b1, 32'h102);
        cycle();
        jump_valid_i = 1'b0;
`ifdef WFC_MISALIGN_CHK_EN
        chk("t6_err", 32'(err_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t6_stopped", 32'(fetch_req_valid_o), 32'd0);
        end
        chk("t6_err_sticky", 32'(err_o), 32'd1);
`else
        chk("t6_err", 32'(err_o), 32'd0);
        cycle();
        chk("t6_valid", 32'(fetch_req_valid_o), 32'd1);
        chk("t6_pc100", fetch_req_pc_o, 32'h100);
`endif

        // Highest warp id and pc wrap-around at 2^32.
        do_reset();
        fetch_req_ready_i = 1'b1;
        start_warp(7, 32'hFFFF_FFFC);
        cycle();
        chk("t7_wid7", 32'(fetch_req_wid_o), 32'd7);
        chk("t7_pc_top", fetch_req_pc_o, 32'hFFFF_FFFC);
        cycle();
        cycle();
        chk("t7_pc_wrap", fetch_req_pc_o, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
